// File: rtl/outport_uart_pkg.sv
// Shared constants and FSM encoding for the out-port UART transmitter.
package outport_uart_pkg;

   localparam int unsigned BITS_PER_BYTE   = 8;
   localparam int unsigned BYTES_PER_WORD  = 4;
   localparam int unsigned CLK_DIV_DEFAULT = 434;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/outport_uart_tx_sync_fifo.sv
// Small synchronous FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push_i,
   input  logic [DATA_WIDTH-1:0]       data_i,
   input  logic                        pop_i,
   output logic [DATA_WIDTH-1:0]       data_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(FIFO_DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  push_ok, pop_ok;

   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/outport_uart_tx.sv
// Out-port consumer: buffers 32-bit words and sends each as four 8N1 bytes, byte 0 first.
module outport_uart_tx
   import outport_uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  busy,
   output logic                  overflow,
   output logic                  tx
);

   localparam int unsigned BAUD_W = $clog2(CLK_DIV);
   localparam int unsigned BIT_W  = $clog2(BITS_PER_BYTE);
   localparam int unsigned BYTE_W = $clog2(BYTES_PER_WORD);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

   tx_state_e             state_q;
   logic [BAUD_W-1:0]     baud_q;
   logic [BIT_W-1:0]      bit_idx_q;
   logic [BYTE_W-1:0]     byte_idx_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  tx_q;
   logic                  overflow_q;

   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_full, fifo_empty;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_pop, baud_zero, last_byte, last_bit, line_bit;

   sync_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (wr_en),
      .data_i (wr_data),
      .pop_i  (fifo_pop),
      .data_o (fifo_data),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .count_o(fifo_count)
   );

   assign baud_zero = (baud_q == '0);
   assign last_byte = (byte_idx_q == BYTE_W'(BYTES_PER_WORD - 1));
   assign last_bit  = (bit_idx_q == BIT_W'(BITS_PER_BYTE - 1));

   // Pop from IDLE, or back-to-back at the end of the last stop bit of a word.
   assign fifo_pop = !fifo_empty &&
                     ((state_q == ST_IDLE) ||
                      (state_q == ST_STOP && baud_zero && last_byte));

   assign full     = fifo_full;
   assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
   assign overflow = overflow_q;
   assign tx       = tx_q;

   // Line level implied by the current state; registered into tx_q.
   always_comb begin
      line_bit = 1'b1;
      unique case (state_q)
         ST_START: line_bit = 1'b0;
         ST_DATA:  line_bit = shift_q[0];
         default:  line_bit = 1'b1;
      endcase
   end

   // Frame sequencer: baud timing, bit/byte counters and the word shifter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_q <= line_bit;
         unique case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  shift_q    <= fifo_data;
                  byte_idx_q <= '0;
                  baud_q     <= BAUD_RELOAD;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               if (baud_zero) begin
                  baud_q    <= BAUD_RELOAD;
                  bit_idx_q <= '0;
                  state_q   <= ST_DATA;
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (baud_zero) begin
                  baud_q  <= BAUD_RELOAD;
                  shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
                  if (last_bit) begin
                     state_q <= ST_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_W'(1);
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            ST_STOP: begin
               if (baud_zero) begin
                  baud_q <= BAUD_RELOAD;
                  if (!last_byte) begin
                     byte_idx_q <= byte_idx_q + BYTE_W'(1);
                     state_q    <= ST_START;
                  end else if (fifo_pop) begin
                     shift_q    <= fifo_data;
                     byte_idx_q <= '0;
                     state_q    <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
         endcase
      end
   end

   // Sticky record of any push attempted while the FIFO was full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (wr_en && fifo_full) begin
         overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Self-checking bench for outport_uart_tx: line decoder plus expected-byte scoreboard.
module tb_outport_uart_tx;

   localparam int unsigned CLK_DIV = 4;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        wr_en   = 1'b0;
   logic [31:0] wr_data = '0;
   logic        full, busy, overflow, tx;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   outport_uart_tx #(
      .CLK_DIV   (CLK_DIV),
      .FIFO_DEPTH(4),
      .DATA_WIDTH(32)
   ) dut (
      .clk     (clk),
      .reset   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .busy    (busy),
      .overflow(overflow),
      .tx      (tx)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
   endtask

   task automatic wait_tx_fall(input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      check_eq("tx_fall_seen", 32'(found), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (busy === 1'b0) found = 1'b1;
      end
      check_eq("idle_seen", 32'(found), 32'd1);
   endtask

   task automatic count_low_cycles(input int cycles, output int lows);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
   endtask

   // Line decoder: a frame starts at the first low sample; bits sampled one cycle into each bit.
   initial begin : decoder
      logic [7:0] byte_v;
      logic       stop_bit, abort;
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            abort    = 1'b0;
            byte_v   = '0;
            stop_bit = 1'b0;
            for (int k = 1; k < 40 && !abort; k++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) abort = 1'b1;
               else if (k >= 5 && k <= 33 && (k % 4) == 1) byte_v[3'((k - 5) / 4)] = tx;
               else if (k == 37) stop_bit = tx;
            end
            if (!abort) begin
               check_eq("frame_stop", 32'(stop_bit), 32'd1);
               check_eq("frame_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  exp_b = exp_q.pop_front();
                  check_eq("frame_byte", 32'(byte_v), 32'(exp_b));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          lows, cnt;
      logic [9:0]  frame;
      logic [31:0] w;

      // Reset state and a quiet idle line.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx",       32'(tx),       32'd1);
      check_eq("rst_full",     32'(full),     32'd0);
      check_eq("rst_busy",     32'(busy),     32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;
      count_low_cycles(100, lows);
      check_eq("idle_no_toggle", 32'(lows), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);

      // Single word 0xA5: exact waveform of first frame and word duration.
      @(negedge clk);
      wr_en = 1'b1; wr_data = 32'h0000_00A5;
      expect_word(32'h0000_00A5);
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("t2_tx_after_push", 32'(tx), 32'd1);
      @(negedge clk);
      check_eq("t2_tx_after_pop", 32'(tx), 32'd1);
      @(negedge clk);
      frame = {1'b1, 8'hA5, 1'b0};
      check_eq("t2_tx_fall", 32'(tx), 32'd0);
      for (int j = 1; j < 40; j++) begin
         @(negedge clk);
         check_eq("t2_line_bit", 32'(tx), 32'((frame >> (j / 4)) & 10'd1));
      end
      repeat (119) @(negedge clk);
      check_eq("t2_busy_last", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("t2_busy_done", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);

      // Word 0x44332211: bytes in order, no gaps between frames.
      @(negedge clk);
      wr_en = 1'b1; wr_data = 32'h4433_2211;
      expect_word(32'h4433_2211);
      @(negedge clk);
      wr_en = 1'b0;
      wait_tx_fall(10);
      cnt = 0;
      while (busy === 1'b1 && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("t3_word_cycles", 32'(cnt), 32'd159);
      repeat (10) @(negedge clk);
      check_eq("t3_drained", 32'(exp_q.size()), 32'd0);

      // Six back-to-back pushes: five accepted, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            check_eq("t4_full_before_6th", 32'(full), 32'd1);
            check_eq("t4_ovf_before_6th",  32'(overflow), 32'd0);
         end
         w = $urandom();
         wr_en = 1'b1; wr_data = w;
         if (i < 5) expect_word(w);
      end
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("t4_full_after_6th", 32'(full), 32'd1);
      check_eq("t4_ovf_after_6th",  32'(overflow), 32'd1);
      wait_idle(1200);
      repeat (10) @(negedge clk);
      check_eq("t4_drained", 32'(exp_q.size()), 32'd0);

      // Push while full on the exact edge of the back-to-back pop.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_eq("t5_ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         w = $urandom();
         wr_en = 1'b1; wr_data = w;
         expect_word(w);
      end
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("t5_full",      32'(full),     32'd1);
      check_eq("t5_ovf_clear", 32'(overflow), 32'd0);
      repeat (156) @(negedge clk);
      check_eq("t5_full_before_pop", 32'(full), 32'd1);
      wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      wr_en = 1'b0;
      check_eq("t5_ovf_set",       32'(overflow), 32'd1);
      check_eq("t5_not_full_after", 32'(full),    32'd0);
      wait_idle(1200);
      repeat (10) @(negedge clk);
      check_eq("t5_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-frame during data bit 3 of byte 1.
      @(negedge clk);
      wr_en = 1'b1; wr_data = 32'hC3B2_A190;
      expect_word(32'hC3B2_A190);
      @(negedge clk);
      wr_en = 1'b0;
      wait_tx_fall(10);
      repeat (57) @(negedge clk);
      check_eq("t6_bit3_value", 32'(tx), 32'd0);
      check_eq("t6_busy_before", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_tx",   32'(tx),   32'd1);
      check_eq("t6_rst_busy", 32'(busy), 32'd0);
      check_eq("t6_rst_full", 32'(full), 32'd0);
      check_eq("t6_byte0_decoded", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      count_low_cycles(200, lows);
      check_eq("t6_no_frames", 32'(lows), 32'd0);
      check_eq("t6_overflow",  32'(overflow), 32'd0);
      check_eq("t6_busy",      32'(busy), 32'd0);
      check_eq("final_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
